// File: rtl/sdc_bridge_pkg.sv
// Purpose : shared types and constants for the SD controller AXI4-Lite to BRAM bridge.
// Contents: FSM state encoding, AXI response codes, arbiter grant encoding.
// Users   : sdc_axil_bram_bridge (import sdc_bridge_pkg::*).
package sdc_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_B    = 3'd2,
    ST_RD   = 3'd3,
    ST_RCAP = 3'd4,
    ST_R    = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

endpackage

// File: rtl/sdc_axil_bram_bridge.sv
// Purpose : AXI4-Lite slave to BRAM master (READ_LATENCY 1) for the SD host register window.
// Latency : write grant T -> bram_en T+1 -> bvalid T+2; read grant T -> bram_en T+1 -> rvalid T+3.
// Backpr. : one transaction in flight; bvalid/rvalid held until bready/rready, no new grant meanwhile.
// Ports   : clk/rst (sync, active-high); s_axil_aw*/w*/b*/ar*/r* AXI4-Lite slave;
//           bram_addr/en/we/wrdata out (registered), bram_rddata in (valid cycle after bram_en).
// Config  : SDC_BRIDGE_DECERR_EN -> addresses above the BRAM window answer SLVERR with no
//           BRAM access; undefined -> upper address bits alias, response always OKAY.
module sdc_axil_bram_bridge
  import sdc_bridge_pkg::*;
#(
  parameter int AddrWidth     = 12,
  parameter int BramAddrWidth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AddrWidth-1:0]     s_axil_awaddr,
  input  logic [2:0]               s_axil_awprot,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [31:0]              s_axil_wdata,
  input  logic [3:0]               s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  input  logic [AddrWidth-1:0]     s_axil_araddr,
  input  logic [2:0]               s_axil_arprot,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic [BramAddrWidth-1:0] bram_addr,
  output logic                     bram_en,
  output logic [3:0]               bram_we,
  output logic [31:0]              bram_wrdata,
  input  logic [31:0]              bram_rddata
);

  state_e                   state_q, state_d;
  logic                     last_grant_q;
  logic                     err_q;
  logic [BramAddrWidth-1:0] bram_addr_q;
  logic                     bram_en_q;
  logic [3:0]               bram_we_q;
  logic [31:0]              bram_wrdata_q;
  logic [31:0]              rdata_q;

  logic wr_elig, rd_elig;
  logic grant_wr, grant_rd;
  logic aw_oob, ar_oob;

  // Protection bits and the byte offset carry no meaning for a word-wide register window.
  logic unused_inputs;
  assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

`ifdef SDC_BRIDGE_DECERR_EN
  assign aw_oob = |s_axil_awaddr[AddrWidth-1:BramAddrWidth+2];
  assign ar_oob = |s_axil_araddr[AddrWidth-1:BramAddrWidth+2];
`else
  assign aw_oob = 1'b0;
  assign ar_oob = 1'b0;
`endif

  // A write needs AW and W together so the address is never taken without its data.
  // On a tie the side that did not win last time goes first.
  always_comb begin
    wr_elig  = s_axil_awvalid && s_axil_wvalid;
    rd_elig  = s_axil_arvalid;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      if (wr_elig && rd_elig) begin
        grant_wr = (last_grant_q == GRANT_RD);
        grant_rd = (last_grant_q == GRANT_WR);
      end else begin
        grant_wr = wr_elig;
        grant_rd = rd_elig;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_wr)      state_d = ST_WR;
        else if (grant_rd) state_d = ST_RD;
      end
      ST_WR:   state_d = ST_B;
      ST_B:    if (s_axil_bready) state_d = ST_IDLE;
      ST_RD:   state_d = ST_RCAP;
      ST_RCAP: state_d = ST_R;
      ST_R:    if (s_axil_rready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture and BRAM drive. The BRAM strobe is loaded in the grant cycle so it
  // appears registered in WR/RD and self-clears the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q  <= GRANT_RD;
      err_q         <= 1'b0;
      bram_addr_q   <= '0;
      bram_en_q     <= 1'b0;
      bram_we_q     <= 4'b0;
      bram_wrdata_q <= 32'b0;
      rdata_q       <= 32'b0;
    end else begin
      bram_en_q <= 1'b0;
      bram_we_q <= 4'b0;
      if (grant_wr) begin
        last_grant_q  <= GRANT_WR;
        err_q         <= aw_oob;
        bram_addr_q   <= s_axil_awaddr[BramAddrWidth+1:2];
        bram_wrdata_q <= s_axil_wdata;
        bram_en_q     <= !aw_oob;
        bram_we_q     <= aw_oob ? 4'b0 : s_axil_wstrb;
      end else if (grant_rd) begin
        last_grant_q <= GRANT_RD;
        err_q        <= ar_oob;
        bram_addr_q  <= s_axil_araddr[BramAddrWidth+1:2];
        bram_en_q    <= !ar_oob;
      end
      // Read data is valid the cycle after the strobe, which is RCAP.
      if (state_q == ST_RCAP) rdata_q <= err_q ? 32'b0 : bram_rddata;
    end
  end

  // Output logic
  always_comb begin
    s_axil_awready = grant_wr;
    s_axil_wready  = grant_wr;
    s_axil_arready = grant_rd;
    s_axil_bvalid  = (state_q == ST_B);
    s_axil_rvalid  = (state_q == ST_R);
    s_axil_bresp   = RESP_OKAY;
    s_axil_rresp   = RESP_OKAY;
    if (s_axil_bvalid && err_q) s_axil_bresp = RESP_SLVERR;
    if (s_axil_rvalid && err_q) s_axil_rresp = RESP_SLVERR;
  end

  assign s_axil_rdata = rdata_q;
  assign bram_addr    = bram_addr_q;
  assign bram_en      = bram_en_q;
  assign bram_we      = bram_we_q;
  assign bram_wrdata  = bram_wrdata_q;

endmodule

// File: tb/tb_sdc_axil_bram_bridge.sv
module tb_sdc_axil_bram_bridge;

`ifdef SDC_BRIDGE_DECERR_EN
  localparam bit DECERR = 1'b1;
`else
  localparam bit DECERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [11:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [7:0]  bram_addr;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_wrdata;
  logic [31:0] bram_rddata;

  int errors = 0;
  int checks = 0;

  sdc_axil_bram_bridge #(.AddrWidth(12), .BramAddrWidth(8)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  // BRAM with one cycle read latency, byte write enables.
  logic [31:0] mem [256];
  logic        mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      bram_rddata <= 32'h0;
    end else if (bram_en) begin
      bram_rddata <= mem[bram_addr];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wrdata[8*b +: 8];
    end
  end

  // Reference model: the register window as seen from the AXI side.
  logic [31:0] exp_mem [256];

  function automatic bit model_oob(input logic [11:0] a);
    return DECERR && (a[11:10] != 2'b00);
  endfunction
  function automatic logic [1:0] model_resp(input logic [11:0] a);
    return model_oob(a) ? 2'b10 : 2'b00;
  endfunction
  function automatic logic [31:0] model_read(input logic [11:0] a);
    return model_oob(a) ? 32'h0 : exp_mem[int'(a[9:2])];
  endfunction
  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (model_oob(a)) return;
    idx = int'(a[9:2]);
    for (int b = 0; b < 4; b++)
      if (s[b]) exp_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input int bdly);
    int n;
    bit ok;
    ok = (er == 2'b00);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 50) begin tick(); n++; end
    chk("wr_grant", {awready, wready}, 2'b11);
    tick();                                 // T+1
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bram_en", bram_en, ok);
    chk("wr_bram_we", bram_we, ok ? s : 4'h0);
    if (ok) begin
      chk("wr_bram_addr", bram_addr, a[9:2]);
      chk("wr_bram_data", bram_wrdata, d);
    end
    chk("wr_bvalid_early", bvalid, 1'b0);
    tick();                                 // T+2
    chk("wr_bvalid", bvalid, 1'b1);
    chk("wr_bresp", bresp, er);
    chk("wr_en_pulse", bram_en, 1'b0);
    for (int k = 0; k < bdly; k++) begin
      tick();
      chk("wr_bvalid_hold", bvalid, 1'b1);
    end
    bready = 1'b1;
    #1;
    tick();
    bready = 1'b0;
    chk("wr_bvalid_drop", bvalid, 1'b0);
    model_write(a, d, s);
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] expd,
                          input logic [1:0] er, input int rdly);
    int n;
    bit ok;
    ok = (er == 2'b00);
    araddr = a; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    chk("rd_grant", arready, 1'b1);
    tick();                                 // T+1
    arvalid = 1'b0;
    chk("rd_bram_en", bram_en, ok);
    chk("rd_bram_we", bram_we, 4'h0);
    if (ok) chk("rd_bram_addr", bram_addr, a[9:2]);
    chk("rd_rvalid_t1", rvalid, 1'b0);
    tick();                                 // T+2
    chk("rd_en_pulse", bram_en, 1'b0);
    chk("rd_rvalid_t2", rvalid, 1'b0);
    tick();                                 // T+3
    chk("rd_rvalid", rvalid, 1'b1);
    chk("rd_rdata", rdata, expd);
    chk("rd_rresp", rresp, er);
    for (int k = 0; k < rdly; k++) begin
      tick();
      chk("rd_rvalid_hold", rvalid, 1'b1);
      chk("rd_rdata_hold", rdata, expd);
    end
    rready = 1'b1;
    #1;
    tick();
    rready = 1'b0;
    chk("rd_rvalid_drop", rvalid, 1'b0);
  endtask

  typedef struct {
    bit          is_wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          dly;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  function automatic vec_t mk(input bit w, input logic [11:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int dl, input logic [31:0] er_d,
                              input logic [1:0] rs);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.dly = dl;
    v.exp_rdata = er_d; v.exp_resp = rs;
    return v;
  endfunction

  vec_t tv [14];
  int   gk [3];
  int   gc [3];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int ng;
    logic [11:0] a;

    for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);

    tv[0]  = mk(1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 32'h0, 2'b00);
    tv[1]  = mk(0, 12'h004, 32'h0, 4'h0, 0, 32'hDEADBEEF, 2'b00);
    tv[2]  = mk(0, 12'h004, 32'h0, 4'h0, 5, 32'hDEADBEEF, 2'b00);
    tv[3]  = mk(1, 12'h010, 32'hA5A5A5A5, 4'hF, 1, 32'h0, 2'b00);
    tv[4]  = mk(1, 12'h010, 32'h00FF00FF, 4'h5, 0, 32'h0, 2'b00);
    tv[5]  = mk(0, 12'h010, 32'h0, 4'h0, 0, 32'hA5FFA5FF, 2'b00);
    tv[6]  = mk(1, 12'h014, 32'hCAFEF00D, 4'hF, 0, 32'h0, 2'b00);
    tv[7]  = mk(1, 12'h014, 32'h12345678, 4'h0, 2, 32'h0, 2'b00);
    tv[8]  = mk(0, 12'h014, 32'h0, 4'h0, 0, 32'hCAFEF00D, 2'b00);
    tv[9]  = mk(1, 12'h000, 32'h0BADF00D, 4'hF, 0, 32'h0, 2'b00);
    tv[10] = mk(0, 12'hC00, 32'h0, 4'h0, 0, DECERR ? 32'h0 : 32'h0BADF00D, DECERR ? 2'b10 : 2'b00);
    tv[11] = mk(1, 12'h800, 32'h55AA55AA, 4'hF, 0, 32'h0, DECERR ? 2'b10 : 2'b00);
    tv[12] = mk(0, 12'h000, 32'h0, 4'h0, 0, DECERR ? 32'h0BADF00D : 32'h55AA55AA, 2'b00);
    tv[13] = mk(0, 12'h3FF, 32'h0, 4'h0, 1, pat(255), 2'b00);

    // Reset state
    repeat (3) tick();
    chk("rst_awready", awready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bram", {bram_en, bram_we, bram_addr, bram_wrdata}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_resp", {bresp, rresp}, 4'h0);
    rst = 1'b0;
    mem_init = 1'b0;
    tick();
    chk("idle_bram_en", bram_en, 1'b0);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      if (tv[i].is_wr)
        axi_write(tv[i].addr, tv[i].data, tv[i].strb, tv[i].exp_resp, tv[i].dly);
      else
        axi_read(tv[i].addr, tv[i].exp_rdata, tv[i].exp_resp, tv[i].dly);
    end

    // AW presented without W: nothing may be accepted
    awaddr = 12'h020; awvalid = 1'b1; wvalid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("aw_only_awready", {awready, wready}, 2'b00);
      chk("aw_only_bram_en", bram_en, 1'b0);
      tick();
    end
    axi_write(12'h020, 32'h600DCAFE, 4'hF, 2'b00, 0);
    axi_read(12'h020, 32'h600DCAFE, 2'b00, 0);

    // Read/write conflict held continuously: grants must alternate W, R, W
    awaddr = 12'h040; wdata = 32'h13579BDF; wstrb = 4'hF; araddr = 12'h044;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    #1;
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      chk("arb_exclusive", awready && arready, 1'b0);
      if (awready && wready) begin gk[ng] = 1; gc[ng] = c; ng++; end
      else if (arready)      begin gk[ng] = 0; gc[ng] = c; ng++; end
      if (ng == 3) break;
      tick();
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("arb_grant_count", ng, 3);
    if (ng == 3) begin
      chk("arb_order", {gk[0][0], gk[1][0], gk[2][0]}, 3'b101);
      chk("arb_first_cycle", gc[0], 0);
      chk("arb_wr_spacing", gc[1] - gc[0], 3);
      chk("arb_rd_spacing", gc[2] - gc[1], 4);
    end
    repeat (4) tick();
    bready = 1'b0; rready = 1'b0;
    chk("arb_drained", {bvalid, rvalid}, 2'b00);
    model_write(12'h040, 32'h13579BDF, 4'hF);
    axi_read(12'h040, 32'h13579BDF, 2'b00, 0);

    // Reset while a read response is pending
    araddr = 12'h004; arvalid = 1'b1;
    #1;
    chk("rstR_grant", arready, 1'b1);
    tick(); arvalid = 1'b0;
    tick(); tick();
    chk("rstR_in_R", rvalid, 1'b1);
    rst = 1'b1;
    tick();
    chk("rstR_rvalid", rvalid, 1'b0);
    chk("rstR_bvalid", bvalid, 1'b0);
    chk("rstR_bram_en", bram_en, 1'b0);
    rst = 1'b0;
    araddr = 12'h004; arvalid = 1'b1;
    #1;
    chk("rstR_arready", arready, 1'b1);
    axi_read(12'h004, model_read(12'h004), model_resp(12'h004), 0);

    // Randomized traffic against the reference model
    for (int k = 0; k < 60; k++) begin
      a = {2'($urandom_range(0, 3)), 4'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), model_resp(a), int'($urandom_range(0, 2)));
      else
        axi_read(a, model_read(a), model_resp(a), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
